// File: rtl/div_32bit_seq.sv
// Sequential 32-bit signed restoring divider: one quotient bit per clock,
// quotient to Rz_lo, remainder to Rz_hi, with a start/busy/done handshake.
module div_32bit_seq (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic [31:0] Ra,
    input  logic [31:0] Rb,
    output logic [31:0] Rz_lo,
    output logic [31:0] Rz_hi,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

    state_t      state, state_nxt;
    logic [31:0] rem;      // partial remainder; always < divisor magnitude, so 32 bits hold it
    logic [31:0] quo;      // dividend magnitude shifting out, quotient bits shifting in
    logic [31:0] dsr;
    logic [4:0]  count;
    logic        sign_q, sign_r;

    logic [31:0] ra_mag, rb_mag;
    logic [32:0] shifted, trial;

    // Magnitudes are taken unsigned, so |0x80000000| stays 0x80000000.
    always_comb begin
        ra_mag  = Ra[31] ? (~Ra + 32'd1) : Ra;
        rb_mag  = Rb[31] ? (~Rb + 32'd1) : Rb;
        shifted = {rem, quo[31]};
        trial   = shifted - {1'b0, dsr};
    end

    // NOTE: every output of a combinational block gets a default before the
    // case statement, otherwise an unassigned path infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (Rb == 32'd0) ? DONE : CALC;
            CALC:    if (count == 5'd31) state_nxt = FIXUP;
            FIXUP:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    always_ff @(posedge clock) begin
        if (!clear) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            rem         <= '0;
            quo         <= '0;
            dsr         <= '0;
            count       <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            Rz_lo       <= '0;
            Rz_hi       <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    rem    <= '0;
                    quo    <= ra_mag;
                    dsr    <= rb_mag;
                    count  <= '0;
                    sign_q <= Ra[31] ^ Rb[31];
                    sign_r <= Ra[31];
                    if (Rb == 32'd0) begin
                        Rz_lo       <= 32'hFFFF_FFFF;
                        Rz_hi       <= Ra;
                        div_by_zero <= 1'b1;
                    end
                end
                CALC: begin
                    // Restoring step: keep the trial difference only when it is non-negative.
                    rem   <= trial[32] ? shifted[31:0] : trial[31:0];
                    quo   <= {quo[30:0], ~trial[32]};
                    count <= count + 5'd1;
                end
                FIXUP: begin
                    Rz_lo       <= sign_q ? (~quo + 32'd1) : quo;
                    Rz_hi       <= sign_r ? (~rem + 32'd1) : rem;
                    div_by_zero <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_div_32bit_seq.sv
// Self-checking bench for div_32bit_seq: a scoreboard queue of expected
// results is filled at each start and drained on every done pulse.
module tb_div_32bit_seq;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic        start = 1'b0;
    logic [31:0] Ra = '0;
    logic [31:0] Rb = '0;
    logic [31:0] Rz_lo, Rz_hi;
    logic        busy, done, div_by_zero;

    typedef struct packed {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dbz;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   k_cyc    = 0;

    div_32bit_seq dut (
        .clock      (clock),
        .clear      (clear),
        .start      (start),
        .Ra         (Ra),
        .Rb         (Rb),
        .Rz_lo      (Rz_lo),
        .Rz_hi      (Rz_hi),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Reference: 64-bit signed arithmetic truncates toward zero, remainder follows dividend.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t   m;
        longint la, lb, q, r;
        if (b == 32'd0) begin
            m.lo  = 32'hFFFF_FFFF;
            m.hi  = a;
            m.dbz = 1'b1;
        end else begin
            la    = longint'($signed(a));
            lb    = longint'($signed(b));
            q     = la / lb;
            r     = la % lb;
            m.lo  = q[31:0];
            m.hi  = r[31:0];
            m.dbz = 1'b0;
        end
        return m;
    endfunction

    // Scoreboard drain: every done pulse must match the oldest pending expectation.
    always @(negedge clock) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                check("spurious_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rz_lo", Rz_lo, e.lo);
                check("rz_hi", Rz_hi, e.hi);
                check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
            end
        end
    end

    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input bit push);
        @(negedge clock);
        Ra    = a;
        Rb    = b;
        start = 1'b1;
        if (push) exp_q.push_back(model(a, b));
        @(negedge clock);
        start = 1'b0;
        k_cyc = cyc;
        // Operands are captured only at the start edge; scramble them afterwards.
        Ra    = $urandom;
        Rb    = $urandom;
    endtask

    task automatic wait_done(input int exp_lat, input bit poke);
        int busy_n = 0;
        bit seen   = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (busy) busy_n++;
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clock);
        end
        check("done_seen", {31'd0, seen}, 32'd1);
        if (seen) begin
            check("latency", cyc - k_cyc, exp_lat);
            check("busy_len", busy_n, exp_lat + 1);
            if (poke) begin
                // start on the DONE->IDLE edge must be dropped
                start = 1'b1;
                Ra    = 32'd7;
                Rb    = 32'd7;
            end
            @(negedge clock);
            start = 1'b0;
            check("done_pulse", {31'd0, done}, 32'd0);
            check("busy_idle", {31'd0, busy}, 32'd0);
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit poke);
        start_op(a, b, 1'b1);
        wait_done((b == 32'd0) ? 0 : 33, poke);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra_r, rb_r;

        repeat (2) @(negedge clock);
        check("rst_lo", Rz_lo, 32'd0);
        check("rst_hi", Rz_hi, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        clear = 1'b1;

        run_op(32'd100, 32'd7, 1'b0);
        run_op(32'hFFFF_FF9C, 32'd7, 1'b1);
        run_op(32'd100, 32'hFFFF_FFF9, 1'b0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(32'h8000_0000, 32'd1, 1'b0);
        run_op(32'd3, 32'h8000_0000, 1'b0);
        run_op(32'd5, 32'd0, 1'b1);
        run_op(32'd9, 32'd3, 1'b0);

        // Abort case: second start is ignored, reset at k+10 kills the operation.
        start_op(32'd50, 32'd5, 1'b0);
        repeat (4) @(negedge clock);
        start = 1'b1;
        Ra    = 32'd1;
        Rb    = 32'd1;
        @(negedge clock);
        start = 1'b0;
        check("busy_during_calc", {31'd0, busy}, 32'd1);
        repeat (4) @(negedge clock);
        clear = 1'b0;
        @(negedge clock);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_lo", Rz_lo, 32'd0);
        check("abort_hi", Rz_hi, 32'd0);
        check("abort_dbz", {31'd0, div_by_zero}, 32'd0);
        clear = 1'b1;
        repeat (3) @(negedge clock);
        run_op(32'd50, 32'd5, 1'b0);

        for (int i = 0; i < 8; i++) begin
            ra_r = $urandom;
            rb_r = $urandom >> $urandom_range(0, 30);
            if (i[0]) rb_r = ~rb_r + 32'd1;
            run_op(ra_r, rb_r, 1'b0);
        end

        repeat (2) @(negedge clock);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
